// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and byte-request type for the character-LCD
// refresh sequencer and its byte writer.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_ADDR_ROW1   = 8'h80;
  localparam logic [7:0] LCD_ADDR_ROW2   = 8'hC0;

  localparam int NUM_INIT = 5;
  localparam int ROW_CHARS = 16;

  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_IDLE  = 3'd2;
  localparam logic [2:0] ST_ADDR1 = 3'd3;
  localparam logic [2:0] ST_ROW1  = 3'd4;
  localparam logic [2:0] ST_ADDR2 = 3'd5;
  localparam logic [2:0] ST_ROW2  = 3'd6;

  typedef enum logic [2:0] {
    PWRUP = ST_PWRUP,
    INIT  = ST_INIT,
    IDLE  = ST_IDLE,
    ADDR1 = ST_ADDR1,
    ROW1  = ST_ROW1,
    ADDR2 = ST_ADDR2,
    ROW2  = ST_ROW2
  } seq_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       long_wait;
  } byte_req_t;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: init_cmd = LCD_CMD_FUNCSET;
      3'd2:       init_cmd = LCD_CMD_DISP_ON;
      3'd3:       init_cmd = LCD_CMD_ENTRY;
      default:    init_cmd = LCD_CMD_CLEAR;
    endcase
  endfunction

  // char0 sits in the top byte, so the slice offset is 8*(15-idx) = {~idx,3'b0}
  function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] idx);
    row_char = row[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one byte onto the LCD bus: setup, enable pulse, then post-byte wait,
// finishing with a single-cycle done pulse.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYC    = 50,
  parameter int SETUP_CYC = 10,
  parameter int CMD_CYC   = 5_000,
  parameter int CLR_CYC   = 200_000,
  parameter int TMR_W     = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  byte_req_t  req,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       done,
  output logic       idle
);

  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_EN, W_WAIT} wr_state_e;

  wr_state_e        st, st_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  logic             long_q;
  logic             ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= W_IDLE;
      tmr      <= '0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      long_q   <= 1'b0;
    end else begin
      st  <= st_nx;
      tmr <= tmr_nx;
      if (ld) begin
        lcd_rs   <= req.rs;
        lcd_data <= req.data;
        long_q   <= req.long_wait;
      end
    end
  end

  // rs/data only load from W_IDLE, so they cannot move while the strobe is high
  always_comb begin
    st_nx  = st;
    tmr_nx = tmr;
    done   = 1'b0;
    ld     = 1'b0;
    case (st)
      W_IDLE: if (start) begin
        ld     = 1'b1;
        st_nx  = W_SETUP;
        tmr_nx = TMR_W'(SETUP_CYC - 1);
      end
      W_SETUP: if (tmr == '0) begin
        st_nx  = W_EN;
        tmr_nx = TMR_W'(EN_CYC - 1);
      end else tmr_nx = tmr - TMR_W'(1);
      W_EN: if (tmr == '0) begin
        st_nx  = W_WAIT;
        tmr_nx = long_q ? TMR_W'(CLR_CYC - 1) : TMR_W'(CMD_CYC - 1);
      end else tmr_nx = tmr - TMR_W'(1);
      W_WAIT: if (tmr == '0) begin
        st_nx = W_IDLE;
        done  = 1'b1;
      end else tmr_nx = tmr - TMR_W'(1);
      default: st_nx = W_IDLE;
    endcase
  end

  assign lcd_e = (st == W_EN);
  assign idle  = (st == W_IDLE);

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// HD44780 16x2 sequencer: power-up wait, init commands, then 34-byte refreshes
// of two snapshotted row buffers on request.
module lcd_refresh_sequencer
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 1_500_000,
  parameter int EN_CYC    = 50,
  parameter int SETUP_CYC = 10,
  parameter int CMD_CYC   = 5_000,
  parameter int CLR_CYC   = 200_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lcd_en,
  input  logic [127:0] lcd_row1,
  input  logic [127:0] lcd_row2,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic [7:0]   lcd_data,
  output logic         busy,
  output logic         init_done
);

  localparam int TMR_MAX = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  seq_state_e       st, st_nx;
  logic [TMR_W-1:0] pw_cnt, pw_nx;
  logic [3:0]       idx, idx_nx;
  logic             pending, pend_nx, done_nx, snap;
  logic [127:0]     sh1, sh2;
  logic             wr_start, wr_done, wr_idle;
  byte_req_t        req;

  lcd_byte_writer #(
    .EN_CYC(EN_CYC), .SETUP_CYC(SETUP_CYC), .CMD_CYC(CMD_CYC),
    .CLR_CYC(CLR_CYC), .TMR_W(TMR_W)
  ) u_wr (
    .clk(clk), .rst_n(rst_n), .start(wr_start), .req(req),
    .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .done(wr_done), .idle(wr_idle)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= PWRUP;
      pw_cnt    <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      init_done <= 1'b0;
      sh1       <= '0;
      sh2       <= '0;
    end else begin
      st        <= st_nx;
      pw_cnt    <= pw_nx;
      idx       <= idx_nx;
      pending   <= pend_nx;
      init_done <= done_nx;
      if (snap) begin
        sh1 <= lcd_row1;
        sh2 <= lcd_row2;
      end
    end
  end

  always_comb begin
    st_nx    = st;
    pw_nx    = pw_cnt;
    idx_nx   = idx;
    pend_nx  = pending;
    done_nx  = init_done;
    snap     = 1'b0;
    wr_start = 1'b0;
    req      = '0;
    if (lcd_en && st != IDLE) pend_nx = 1'b1;
    case (st)
      PWRUP: begin
        if (pw_cnt == TMR_W'(PWRUP_CYC - 1)) begin
          st_nx = INIT;
          pw_nx = '0;
        end else pw_nx = pw_cnt + TMR_W'(1);
      end
      INIT: begin
        req.data      = init_cmd(idx[2:0]);
        req.long_wait = (idx == 4'(NUM_INIT - 1));
        wr_start      = wr_idle;
        if (wr_done) begin
          if (idx == 4'(NUM_INIT - 1)) begin
            idx_nx  = '0;
            done_nx = 1'b1;
            st_nx   = IDLE;
          end else idx_nx = idx + 4'd1;
        end
      end
      IDLE: if (lcd_en || pending) begin
        snap    = 1'b1;
        pend_nx = 1'b0;
        st_nx   = ADDR1;
      end
      ADDR1: begin
        req.data = LCD_ADDR_ROW1;
        wr_start = wr_idle;
        if (wr_done) st_nx = ROW1;
      end
      ROW1: begin
        req.rs   = 1'b1;
        req.data = row_char(sh1, idx);
        wr_start = wr_idle;
        if (wr_done) begin
          idx_nx = idx + 4'd1;
          if (idx == 4'(ROW_CHARS - 1)) st_nx = ADDR2;
        end
      end
      ADDR2: begin
        req.data = LCD_ADDR_ROW2;
        wr_start = wr_idle;
        if (wr_done) st_nx = ROW2;
      end
      ROW2: begin
        req.rs   = 1'b1;
        req.data = row_char(sh2, idx);
        wr_start = wr_idle;
        if (wr_done) begin
          idx_nx = idx + 4'd1;
          if (idx == 4'(ROW_CHARS - 1)) st_nx = IDLE;
        end
      end
      default: st_nx = PWRUP;
    endcase
  end

  assign lcd_rw = 1'b0;
  assign busy   = (st != IDLE);

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Self-checking bench: a byte-stream/timing model predicts every LCD write and
// the busy/init_done flags; a negedge process compares each cycle.
module tb_lcd_refresh_sequencer;
  localparam int PWRUP = 20, EN = 2, SETUP = 1, CMD = 4, CLR = 10;

  logic clk = 1'b0, rst_n, lcd_en;
  logic [127:0] row1, row2;
  logic lcd_rs, lcd_rw, lcd_e, busy, init_done;
  logic [7:0] lcd_data;

  lcd_refresh_sequencer #(.PWRUP_CYC(PWRUP), .EN_CYC(EN), .SETUP_CYC(SETUP),
                          .CMD_CYC(CMD), .CLR_CYC(CLR)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_row1(row1), .lcd_row2(row2),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .busy(busy), .init_done(init_done));

  always #5 clk = ~clk;

  typedef struct {logic rs; logic [7:0] data; bit first; bit last; bit long_w; bit refr;} exp_t;
  exp_t q[$];
  exp_t cur;
  int checks = 0, failures = 0;
  int cyc = 0, idle_at = 32'h3fff_ffff, burst_start = 0, last_fall = 0, rise_cyc = 0;
  int last_w = 0, idx = 0, init_done_cyc = 0, init_rise = 0, ref_rise = 0, nref = 0;
  bit m_pend = 0, m_busy = 1, m_init_done = 0, m_act = 0, prev_e = 0, prev_done = 0, in_ref = 0;
  logic [7:0] cap [0:33];
  logic [7:0] init_seq [0:4] = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_refresh(input logic [127:0] r1, input logic [127:0] r2);
    q.push_back('{rs:1'b0, data:8'h80, first:1, last:0, long_w:0, refr:1});
    for (int i = 0; i < 16; i++)
      q.push_back('{rs:1'b1, data:r1[127-8*i -: 8], first:0, last:0, long_w:0, refr:1});
    q.push_back('{rs:1'b0, data:8'hC0, first:0, last:0, long_w:0, refr:1});
    for (int i = 0; i < 16; i++)
      q.push_back('{rs:1'b1, data:r2[127-8*i -: 8], first:0, last:(i == 15), long_w:0, refr:1});
  endtask

  // Model: which bytes must appear and when the sequencer is idle
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0; q.delete(); m_pend = 0; m_busy = 1; m_init_done = 0; m_act = 0;
      idle_at = 32'h3fff_ffff;
    end else begin
      cyc++;
      if (cyc == 1) begin
        for (int i = 0; i < 5; i++)
          q.push_back('{rs:1'b0, data:init_seq[i], first:(i == 0), last:(i == 4), long_w:(i == 4), refr:0});
        burst_start = PWRUP; m_act = 1;
      end
      if (!m_act && cyc - 1 >= idle_at && (lcd_en || m_pend)) begin
        push_refresh(row1, row2);
        m_pend = 0; m_act = 1; burst_start = cyc;
      end else if (lcd_en) m_pend = 1;
      m_busy = !(!m_act && cyc >= idle_at);
      if (!m_busy) m_init_done = 1;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_e", lcd_e, 0); chk("rst_rs", lcd_rs, 0); chk("rst_data", lcd_data, 0);
      chk("rst_busy", busy, 1); chk("rst_init_done", init_done, 0); chk("rst_rw", lcd_rw, 0);
      prev_e = 0; prev_done = 0; in_ref = 0;
    end else begin
      chk("busy", busy, m_busy); chk("init_done", init_done, m_init_done); chk("rw", lcd_rw, 0);
      if (lcd_e && !prev_e) begin
        if (q.size() == 0) chk("unexpected_byte", {lcd_rs, lcd_data}, 32'hdead);
        else begin
          cur = q.pop_front();
          chk("byte_rs", lcd_rs, cur.rs); chk("byte_data", lcd_data, cur.data);
          if (cur.first) begin
            idx = 0; in_ref = cur.refr;
            chk("first_rise_latency", cyc, burst_start + 1 + SETUP);
            if (cur.refr) ref_rise = cyc; else init_rise = cyc;
          end else begin
            idx++;
            chk("byte_gap", cyc - last_fall, last_w + 1 + SETUP);
          end
          if (cur.refr) cap[idx] = lcd_data;
          rise_cyc = cyc;
        end
      end else if (lcd_e && prev_e) begin
        chk("stable_rs", lcd_rs, cur.rs); chk("stable_data", lcd_data, cur.data);
      end else if (!lcd_e && prev_e) begin
        chk("e_width", cyc - rise_cyc, EN);
        last_fall = cyc; last_w = cur.long_w ? CLR : CMD;
        if (cur.last) begin
          m_act = 0; idle_at = cyc + last_w;
          if (cur.refr) nref++;
        end
      end
      if (init_done && !prev_done) init_done_cyc = cyc;
      prev_e = lcd_e; prev_done = init_done;
    end
  end

  task automatic pulse_en();
    @(negedge clk); #1 lcd_en = 1'b1;
    @(negedge clk); #1 lcd_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(!m_busy && !m_pend && q.size() == 0) && n < limit) begin
      @(negedge clk); n++;
    end
    chk("idle_timeout", n < limit, 1);
    @(negedge clk);
  endtask

  task automatic wait_idx(input int n, input bit need_e, input int limit);
    int k = 0;
    while (!(in_ref && idx >= n && (!need_e || lcd_e)) && k < limit) begin
      @(negedge clk); k++;
    end
    chk("idx_timeout", k < limit, 1);
  endtask

  initial begin
    rst_n = 1'b0; lcd_en = 1'b0; row1 = '0; row2 = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    // 1: init only
    wait_idle(500);
    chk("init_first_rise", init_rise, 22);
    chk("init_done_cycle", init_done_cyc, 66);
    // 2/3: refresh, row1 modified mid-ROW1
    row1 = "  Cold Storage  "; row2 = "Humi: 27%       ";
    pulse_en();
    wait_idx(5, 0, 500);
    row1 = "Temp: 05 C      ";
    wait_idle(1000);
    chk("nref_after_t3", nref, 1);
    chk("cap_addr1", cap[0], 8'h80); chk("cap_addr2", cap[17], 8'hC0);
    chk("cap_r1c2", cap[3], 8'h43); chk("cap_r1c3", cap[4], 8'h6F);
    chk("cap_r2c6", cap[24], 8'h32);
    // 4: three requests during a refresh collapse to one
    pulse_en();
    wait_idx(3, 0, 500);
    repeat (3) begin pulse_en(); @(negedge clk); end
    row2 = "Humi: 31%       ";
    wait_idle(2000);
    chk("nref_after_t4", nref, 3);
    chk("cap_r1c0_new", cap[1], 8'h54); chk("cap_r2c6_new", cap[24], 8'h33);
    // 6: reset while lcd_e high in ROW2
    pulse_en();
    wait_idx(20, 1, 1000);
    #1 rst_n = 1'b0;
    #1 chk("async_e_drop", lcd_e, 0);
    chk("async_busy", busy, 1); chk("async_init_done", init_done, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    // 5: request during PWRUP runs right after init
    repeat (5) @(negedge clk);
    pulse_en();
    wait_idle(2000);
    chk("reinit_first_rise", init_rise, 22);
    chk("reinit_done_cycle", init_done_cyc, 66);
    chk("pwrup_req_rise", ref_rise, 69);
    chk("nref_after_t5", nref, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

endmodule
